w4a8_requant_out: RTL and testbench
===================================

W4A8_REQUANT_OUT -- requirements
Module: w4a8_requant_out

Interface
REQ-001 SHALL have parameter M, default 8, rows per accumulator tile.
REQ-002 SHALL have parameter N, default 8, columns per tile (output channels).
REQ-003 SHALL have parameter RESULT_WIDTH, default 32, signed accumulator element width.
REQ-004 SHALL have parameter SCALE_WIDTH, default 16, unsigned per-channel scale width.
REQ-005 SHALL have parameter OUT_WIDTH, default 8, signed output element width.
REQ-006 SHALL have parameter TILE_FIFO_DEPTH, default 2, tiles buffered (power of two, >=2).
REQ-007 SHALL have ports: clk  input  1  single clock, all logic on rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports: acc_1d  input  M*N*RESULT_WIDTH  tile from GEMM stage, element (i,j) at bits [(i*N+j)*RESULT_WIDTH +: RESULT_WIDTH]; acc_valid  input  1  one-cycle tile strobe, no backpressure.
REQ-009 SHALL have ports: cfg_scale_1d  input  N*SCALE_WIDTH  scale of column j at [j*SCALE_WIDTH +: SCALE_WIDTH]; cfg_shift  input  5  right-shift amount; err_clr  input  1  clears ovf_err.
REQ-010 SHALL have ports: out_row  output  N*OUT_WIDTH  one quantized row, column j at [j*OUT_WIDTH +: OUT_WIDTH]; out_valid  output  1; out_ready  input  1; out_last  output  1  marks row M-1; busy  output  1; ovf_err  output  1  sticky.

Function
REQ-011 SHALL write acc_1d into the tile FIFO in every cycle acc_valid=1 and FIFO not full.
REQ-012 SHALL drop the tile, leave FIFO contents unchanged and set ovf_err when acc_valid=1 and FIFO full; ovf_err clears only on err_clr=1 (set wins if both same cycle).
REQ-013 SHALL run FSM IDLE -> RUN: IDLE moves to RUN when FIFO non-empty, loading row counter 0; RUN issues one row per advance; after issuing row M-1 pops the FIFO and returns to IDLE, or stays in RUN with counter 0 if another tile is queued.
REQ-014 SHALL implement a 2-stage row pipeline: stage 1 registers N products acc(i,j)*scale(j) (RESULT_WIDTH+SCALE_WIDTH+1 bits signed); stage 2 shifts, rounds, saturates into the out_row register.
REQ-015 SHALL advance the whole pipeline (issue, stage 1, stage 2) only when out_valid=0 or out_ready=1; otherwise all stages hold.
REQ-016 SHALL hold out_row, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-017 SHALL give first out_valid 3 cycles after an accepted acc_valid into an empty idle block with out_ready=1, then one row per cycle, M rows per tile in row order 0..M-1.
REQ-018 SHALL compute y = product >>> cfg_shift (arithmetic), then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-019 SHALL assert out_last with the out_valid beat of row M-1 only.
REQ-020 SHALL assert busy when FSM is RUN, FIFO non-empty or any pipeline stage holds valid data.
REQ-021 SHALL require cfg_scale_1d and cfg_shift stable while busy=1; changes then are undefined.
REQ-022 SHALL accept a write and a pop in the same cycle on a full FIFO without asserting ovf_err only if the pop precedes the write (pop frees the slot in that cycle).

Reset
REQ-023 SHALL on rst_n=0 immediately clear FIFO pointers, FSM to IDLE, row counter, pipeline valids; out_valid=0, out_last=0, out_row=0, busy=0, ovf_err=0.
REQ-024 SHALL discard all in-flight and queued tiles on reset mid-operation; reset release is synchronised internally (async assert, sync deassert).

Configuration
REQ-025 SHALL support macro REQUANT_ROUND_EN: defined -> add 2^(cfg_shift-1) before the shift when cfg_shift>0 (round half up); undefined -> pure truncating arithmetic shift (floor).

Verification
REQ-026 SHALL check: acc all 100, scale all 3, shift 2, out_ready=1 -> 8 rows of 75, out_last on row 7, first beat 3 cycles after acc_valid.
REQ-027 SHALL check: acc=5, scale=1, shift=1 -> output 3 with REQUANT_ROUND_EN, 2 without; acc=-5 -> -2 with, -3 without.
REQ-028 SHALL check saturation: acc=100000, scale=1, shift=0 -> 127; acc=-100000 -> -128.
REQ-029 SHALL check backpressure: out_ready low 5 cycles mid-tile -> out_row held stable, no row lost or duplicated, order preserved.
REQ-030 SHALL check overflow: out_ready=0, 3 acc_valid strobes with depth 2 -> ovf_err=1, later output contains exactly tiles 1 and 2; err_clr -> ovf_err=0.
REQ-031 SHALL check reset: rst_n low mid-tile -> out_valid=0 and busy=0 same cycle; after release no stale rows emitted.

Source files
------------

// File: rtl/w4a8_requant_out.sv
// Requantization output stage: tile FIFO, row sequencer and a 2-stage scale/shift/saturate pipeline.
// Optional macro REQUANT_ROUND_EN selects round-half-up before the shift (default: floor shift).
module w4a8_requant_out #(
   parameter int unsigned M               = 8,
   parameter int unsigned N               = 8,
   parameter int unsigned RESULT_WIDTH    = 32,
   parameter int unsigned SCALE_WIDTH     = 16,
   parameter int unsigned OUT_WIDTH       = 8,
   parameter int unsigned TILE_FIFO_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [M*N*RESULT_WIDTH-1:0]     acc_1d,
   input  logic                            acc_valid,
   input  logic [N*SCALE_WIDTH-1:0]        cfg_scale_1d,
   input  logic [4:0]                      cfg_shift,
   input  logic                            err_clr,
   output logic [N*OUT_WIDTH-1:0]          out_row,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_last,
   output logic                            busy,
   output logic                            ovf_err
);
   localparam int unsigned ProdW = RESULT_WIDTH + SCALE_WIDTH + 1;
   localparam int unsigned TileW = M * N * RESULT_WIDTH;
   localparam int unsigned PtrW  = $clog2(TILE_FIFO_DEPTH);
   localparam int unsigned RowW  = (M > 1) ? $clog2(M) : 1;
   localparam logic [RowW-1:0] LastRow = RowW'(M - 1);
   localparam logic [PtrW:0]   PtrOne  = (PtrW + 1)'(1);
   localparam logic signed [ProdW:0] OutMax =
      {{(ProdW - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [ProdW:0] OutMin = ~OutMax;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   logic [1:0]              rst_sync_q;
   logic                    rst_done;
   logic [TileW-1:0]        fifo_mem [TILE_FIFO_DEPTH];
   logic [PtrW:0]           wr_ptr_q, rd_ptr_q, fifo_cnt;
   logic                    fifo_empty, fifo_full, fifo_wr, fifo_pop;
   state_e                  state_q, state_d;
   logic [RowW-1:0]         row_q, row_d;
   logic                    issue, adv;
   logic [TileW-1:0]        head;
   logic signed [ProdW-1:0] acc_ext, scl_ext;
   logic signed [ProdW-1:0] prod_d [N];
   logic signed [ProdW-1:0] prod_q [N];
   logic                    s1_valid_q, s1_last_q;
   logic signed [ProdW:0]   wide, shifted;
   logic [N*OUT_WIDTH-1:0]  quant_row;

   // Reset asserts asynchronously; state stays cleared until release has passed two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_done = rst_sync_q[1];

   assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == (PtrW + 1)'(TILE_FIFO_DEPTH));
   assign adv        = rst_done && (!out_valid || out_ready);
   // A pop in the same cycle frees the slot for an incoming tile.
   assign fifo_wr    = rst_done && acc_valid && (!fifo_full || fifo_pop);

   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wr_ptr_q[PtrW-1:0]] <= acc_1d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_err  <= 1'b0;
      end else if (rst_done) begin
         if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PtrOne;
         if (fifo_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
         if (acc_valid && !fifo_wr) ovf_err <= 1'b1;
         else if (err_clr)          ovf_err <= 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      issue    = 1'b0;
      fifo_pop = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d = StRun;
               row_d   = '0;
            end
         end
         StRun: begin
            if (adv) begin
               issue = 1'b1;
               if (row_q == LastRow) begin
                  fifo_pop = 1'b1;
                  row_d    = '0;
                  if (!(fifo_cnt > PtrOne || acc_valid)) state_d = StIdle;
               end else begin
                  row_d = row_q + RowW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         row_q   <= '0;
      end else if (rst_done) begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   // Stage 1 operands: signed accumulator times zero-extended scale.
   always_comb begin
      head    = fifo_mem[rd_ptr_q[PtrW-1:0]];
      acc_ext = '0;
      scl_ext = '0;
      for (int j = 0; j < N; j++) begin
         acc_ext   = ProdW'($signed(head[(int'(row_q) * N + j) * RESULT_WIDTH +: RESULT_WIDTH]));
         scl_ext   = ProdW'(cfg_scale_1d[j*SCALE_WIDTH +: SCALE_WIDTH]);
         prod_d[j] = acc_ext * scl_ext;
      end
   end

   always_comb begin
      wide      = '0;
      shifted   = '0;
      quant_row = '0;
      for (int j = 0; j < N; j++) begin
         wide = {prod_q[j][ProdW-1], prod_q[j]};
`ifdef REQUANT_ROUND_EN
         if (cfg_shift != 5'd0) wide = wide + ((ProdW + 1)'(1) << (cfg_shift - 5'd1));
`endif
         shifted = wide >>> cfg_shift;
         if (shifted > OutMax)      quant_row[j*OUT_WIDTH +: OUT_WIDTH] = OutMax[OUT_WIDTH-1:0];
         else if (shifted < OutMin) quant_row[j*OUT_WIDTH +: OUT_WIDTH] = OutMin[OUT_WIDTH-1:0];
         else                       quant_row[j*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         for (int j = 0; j < N; j++) prod_q[j] <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_row    <= '0;
      end else if (adv) begin
         s1_valid_q <= issue;
         s1_last_q  <= issue && (row_q == LastRow);
         if (issue) begin
            for (int j = 0; j < N; j++) prod_q[j] <= prod_d[j];
         end
         out_valid <= s1_valid_q;
         out_last  <= s1_valid_q && s1_last_q;
         if (s1_valid_q) out_row <= quant_row;
      end
   end

   assign busy = (state_q == StRun) || !fifo_empty || s1_valid_q || out_valid;

endmodule

// File: tb/tb_w4a8_requant_out.sv
// Self-checking bench for w4a8_requant_out: table vectors, hand-written corner sequences and
// randomized tiles checked against an arithmetic reference model and an expected-row queue.
module tb_w4a8_requant_out;
   localparam int M  = 8;
   localparam int N  = 8;
   localparam int RW = 32;
   localparam int SW = 16;
   localparam int OW = 8;
   localparam int TW = M * N * RW;

   logic            clk, rst_n;
   logic [TW-1:0]   acc_1d;
   logic            acc_valid;
   logic [N*SW-1:0] cfg_scale_1d;
   logic [4:0]      cfg_shift;
   logic            err_clr;
   logic [N*OW-1:0] out_row;
   logic            out_valid, out_ready, out_last, busy, ovf_err;

   typedef struct {
      logic [N*OW-1:0] row;
      logic            last;
   } exp_t;

   typedef struct {
      int acc;
      int scale;
      int shift;
      int expv;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[12];
   int   checks = 0;
   int   errors = 0;
   int   av[M][N];
   int   ev[M][N];
   int   scl[N];
   int   shamt;
   int   ready_mode = 0;

   w4a8_requant_out #(
      .M(M), .N(N), .RESULT_WIDTH(RW), .SCALE_WIDTH(SW), .OUT_WIDTH(OW), .TILE_FIFO_DEPTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .acc_1d(acc_1d), .acc_valid(acc_valid),
      .cfg_scale_1d(cfg_scale_1d), .cfg_shift(cfg_shift), .err_clr(err_clr),
      .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .ovf_err(ovf_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Reference: floor((acc*scale [+ half]) / 2^shift), clamped to the output range.
   function automatic int ref_q(input int a, input int s, input int sh);
      longint p, d, q;
      longint hi = (longint'(1) << (OW - 1)) - 1;
      longint lo = -(longint'(1) << (OW - 1));
      p = longint'(a) * longint'(s);
`ifdef REQUANT_ROUND_EN
      if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
      d = longint'(1) << sh;
      q = p / d;
      if ((p % d != 0) && (p < 0)) q = q - 1;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return int'(q);
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic apply_cfg();
      for (int j = 0; j < N; j++) cfg_scale_1d[j*SW +: SW] = SW'(scl[j]);
      cfg_shift = 5'(shamt);
   endtask

   task automatic run_model();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) ev[i][j] = ref_q(av[i][j], scl[j], shamt);
   endtask

   task automatic push_exp();
      exp_t e;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) e.row[j*OW +: OW] = OW'(ev[i][j]);
         e.last = (i == M - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic fill_uniform(input int a, input int s, input int sh, input int y);
      for (int j = 0; j < N; j++) scl[j] = s;
      shamt = sh;
      apply_cfg();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) begin
            av[i][j] = a;
            ev[i][j] = y;
         end
   endtask

   task automatic fill_pattern(input int k);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) av[i][j] = k * 20 + i * 2 + j;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that sampled acc_valid.
   task automatic send_tile();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) acc_1d[(i*N+j)*RW +: RW] = RW'(av[i][j]);
      acc_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      int quiet = 0;
      while ((busy || exp_q.size() != 0) && n < 2000 && quiet < 20) begin
         @(posedge clk);
         #1;
         n++;
         quiet = busy ? 0 : quiet + 1;
      end
      checks++;
      if (busy || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got busy=%0b pending=%0d want busy=0 pending=0",
                  name, busy, exp_q.size());
      end
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: every accepted beat must match the head of the expected queue, and a
   // stalled beat must be held unchanged.
   initial begin
      exp_t        e;
      logic        stalled = 1'b0;
      logic [N*OW-1:0] held_row;
      logic        held_last;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== held_row || out_last !== held_last) begin
               errors++;
               $display("FAIL stall_hold got v=%0b row=%h last=%0b want v=1 row=%h last=%0b",
                        out_valid, out_row, out_last, held_row, held_last);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_row got row=%h last=%0b want no beat", out_row, out_last);
            end else begin
               e = exp_q.pop_front();
               if (out_row !== e.row || out_last !== e.last) begin
                  errors++;
                  $display("FAIL row_beat got row=%h last=%0b want row=%h last=%0b",
                           out_row, out_last, e.row, e.last);
               end
            end
         end
         stalled   = out_valid && !out_ready;
         held_row  = out_row;
         held_last = out_last;
      end
   end

   initial begin
      vecs[0]  = '{100, 3, 2, 75};
`ifdef REQUANT_ROUND_EN
      vecs[1]  = '{5, 1, 1, 3};
      vecs[2]  = '{-5, 1, 1, -2};
      vecs[3]  = '{7, 65535, 16, 7};
      vecs[4]  = '{-1, 1, 4, 0};
`else
      vecs[1]  = '{5, 1, 1, 2};
      vecs[2]  = '{-5, 1, 1, -3};
      vecs[3]  = '{7, 65535, 16, 6};
      vecs[4]  = '{-1, 1, 4, -1};
`endif
      vecs[5]  = '{100000, 1, 0, 127};
      vecs[6]  = '{-100000, 1, 0, -128};
      vecs[7]  = '{127, 1, 0, 127};
      vecs[8]  = '{128, 1, 0, 127};
      vecs[9]  = '{-129, 1, 0, -128};
      vecs[10] = '{0, 65535, 0, 0};
      vecs[11] = '{2147483647, 65535, 31, 127};

      rst_n = 1'b1; acc_valid = 1'b0; err_clr = 1'b0;
      acc_1d = '0; cfg_scale_1d = '0; cfg_shift = '0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_row", out_row, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf_err", ovf_err, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // First-beat latency: three edges after the edge that samples acc_valid.
      fill_uniform(100, 3, 2, 75);
      push_exp();
      send_tile();
      @(posedge clk); #1; check("lat_e1_valid", out_valid, 0);
      @(posedge clk); #1; check("lat_e2_valid", out_valid, 0);
      @(posedge clk); #1; check("lat_e3_valid", out_valid, 1);
      wait_idle("latency");

      for (int v = 0; v < 12; v++) begin
         fill_uniform(vecs[v].acc, vecs[v].scale, vecs[v].shift, vecs[v].expv);
         push_exp();
         send_tile();
         wait_idle($sformatf("vec%0d", v));
      end

      // Backpressure: stall five cycles mid-tile.
      for (int j = 0; j < N; j++) scl[j] = 1;
      shamt = 0;
      apply_cfg();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) av[i][j] = i * 10 + j;
      run_model();
      push_exp();
      send_tile();
      repeat (4) begin @(posedge clk); #1; end
      ready_mode = 2;
      repeat (3) begin @(posedge clk); #1; end
      check("bp_valid_held", out_valid, 1);
      repeat (2) begin @(posedge clk); #1; end
      ready_mode = 0;
      wait_idle("backpressure");

      // Overflow: third tile dropped while output is stalled.
      ready_mode = 2;
      @(posedge clk); #1;
      fill_pattern(1); run_model(); push_exp(); send_tile();
      fill_pattern(2); run_model(); push_exp(); send_tile();
      check("ovf_before_third", ovf_err, 0);
      fill_pattern(3); send_tile();
      check("ovf_after_third", ovf_err, 1);
      repeat (3) begin @(posedge clk); #1; end
      ready_mode = 0;
      wait_idle("overflow");
      check("ovf_sticky", ovf_err, 1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("ovf_cleared", ovf_err, 0);

      // Full FIFO: write lands in the same cycle as the pop of tile 1 -> no overflow.
      fill_pattern(4); run_model(); push_exp(); send_tile();
      fill_pattern(5); run_model(); push_exp(); send_tile();
      repeat (7) begin @(posedge clk); #1; end
      fill_pattern(6); run_model(); push_exp(); send_tile();
      check("pop_write_no_ovf", ovf_err, 0);
      wait_idle("pop_write");
      check("pop_write_ovf_after", ovf_err, 0);

      // Randomized tiles against the reference model with random output stalls.
      ready_mode = 1;
      for (int b = 0; b < 25; b++) begin
         for (int j = 0; j < N; j++)
            scl[j] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535))
                                                 : int'($urandom_range(0, 8));
         shamt = int'($urandom_range(0, 20));
         apply_cfg();
         for (int t = 0; t < int'($urandom_range(1, 2)); t++) begin
            for (int i = 0; i < M; i++)
               for (int j = 0; j < N; j++)
                  case ($urandom_range(0, 2))
                     0:       av[i][j] = int'($urandom_range(0, 400)) - 200;
                     1:       av[i][j] = int'($urandom_range(0, 40000)) - 20000;
                     default: av[i][j] = int'($urandom);
                  endcase
            run_model();
            push_exp();
            send_tile();
         end
         wait_idle($sformatf("rand%0d", b));
      end
      ready_mode = 0;

      // Reset mid-tile: outputs drop at once and nothing stale follows.
      for (int j = 0; j < N; j++) scl[j] = 1;
      shamt = 0;
      apply_cfg();
      fill_pattern(2); run_model(); push_exp(); send_tile();
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_out_last", out_last, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      check("postrst_busy", busy, 0);
      check("postrst_out_valid", out_valid, 0);
      fill_pattern(3); run_model(); push_exp(); send_tile();
      wait_idle("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
